wb_write_sequencer: RTL and testbench
=====================================

Name: wb_write_sequencer

Overview:
- Write-side front end of the register file's single write port.
- Accepts register-write requests from two pipeline sources: ALU results (EXE/MEM path) and load data returning from data memory.
- Queues the requests and presents exactly one write per cycle to the register file.
- Drives stall back-pressure to the pipeline and offers a pending-write lookup so ID can forward values not yet written.

Parameters:
DEPTH, 4, pending-write queue entries (power of two, >= 2)
DW, 32, data width of written values
AW, 4, register index width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
alu_wb_en  in  1  ALU write request valid this cycle
alu_dest  in  AW  ALU destination register
alu_result  in  DW  ALU value
mem_wb_en  in  1  load write request valid this cycle
mem_dest  in  AW  load destination register
mem_data  in  DW  load value
wb_en  out  1  write-enable to register file
wb_dest  out  AW  destination to register file
wb_value  out  DW  value to register file
wb_stall  out  1  free slots < 2; pipeline must hold new requests
fwd_src  in  AW  lookup index from ID stage
fwd_hit  out  1  a pending write targets fwd_src
fwd_value  out  DW  value of newest pending write to fwd_src
occupancy  out  clog2(DEPTH)+1  entries in queue (excludes output register)
overflow  out  1  sticky: a request was dropped because the queue was full
bad_dest  out  1  sticky: a request targeted register 15

Behaviour:
- Reset, synchronous on posedge with rst=1:
  - wb_en=0, wb_dest=0, wb_value=0, occupancy=0, wb_stall=0, overflow=0, bad_dest=0, fwd_hit=0.
  - Queue is emptied; requests presented in the same cycle are discarded.
- Register 15 (PC) is not writable.
  - A request with dest==15 is discarded and sets bad_dest.
  - It never enters the queue and never reaches wb_*.
- Ordering within a cycle: the load request is older than the ALU request.
- Each posedge forms the ordered list of candidates: queue entries (oldest first), then a valid mem request, then a valid alu request.
  - Output register (wb_en/wb_dest/wb_value) loads the first candidate; wb_en=1.
  - If there are no candidates, wb_en=0; wb_dest and wb_value hold their last values.
  - The remaining incoming requests are pushed into the queue in order (mem, then alu).
- Latency: into an empty queue, a request appears on wb_* in the cycle after its accepting edge. The register file captures it on the following negedge.
- Throughput: exactly one write retired per cycle while the queue or an input is non-empty.
- Net queue change per edge: +pushes − (1 if the queue was non-empty).
- wb_stall is combinational from the current state: high when DEPTH − occupancy < 2.
- Full queue: if a push finds no free slot, that request is dropped and overflow sets. The pop in the same edge is credited first, so a simultaneous pop+push on a full queue never overflows.
- overflow and bad_dest clear only on reset.
- Queue is a circular buffer with head/tail pointers wrapping modulo DEPTH. occupancy is an explicit counter, so the full and empty states are distinguishable.
- Same destination queued more than once: all writes retire in order; the register file ends with the newest value.
- Reset asserted while entries are pending: all are lost; no further wb_en pulses occur.

Optional Feature:
WB_FWD_EN
- Defined:
  - fwd_hit/fwd_value are combinational over the output register (when wb_en=1) plus all valid queue entries.
  - The newest matching entry wins; the output register is the oldest.
  - Same-cycle alu/mem inputs are not searched.
  - fwd_src==15 never hits.
- Undefined: fwd_hit=0 and fwd_value=0 constantly; fwd_src is ignored; no comparator logic is built.

Test Plan:
- Reset then idle 5 cycles -> wb_en=0, occupancy=0, wb_stall=0, overflow=0 throughout.
- Single alu request dest=3, value=0x0000_00AA -> next cycle wb_en=1, wb_dest=3, wb_value=0xAA; the cycle after, wb_en=0.
- Same cycle: mem dest=5 data=0x11 and alu dest=6 result=0x22 -> wb_* shows (5,0x11) then (6,0x22) on consecutive cycles; occupancy 1 then 0.
- Dual requests every cycle for 3 cycles with DEPTH=4 -> wb_stall rises when occupancy reaches 3. A fourth forced dual cycle at occupancy 3 fills the queue to 4 via pop credit with overflow=0. A fifth dual cycle drops one request and sets overflow. The queue then drains in exact order.
- alu dest=15 -> no wb_en pulse; bad_dest=1 until rst.
- WB_FWD_EN:
  - Queue alu dest=2 values 0x10 then 0x20, with fwd_src=2 -> fwd_hit=1, fwd_value=0x20 until the second write retires.
  - fwd_src=7 -> fwd_hit=0.
  - Macro undefined -> fwd_hit=0 always.
- rst asserted with occupancy=3 -> next cycle occupancy=0, wb_en=0, no further writes.

Source files
------------

// File: rtl/wb_write_sequencer.sv
// Register-file write sequencer: merges load and ALU write requests into one write per cycle.
// Optional macro WB_FWD_EN builds the pending-write lookup (fwd_hit/fwd_value) for the ID stage.
module wb_write_sequencer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_wb_en,
    input  logic [AW-1:0]              alu_dest,
    input  logic [DW-1:0]              alu_result,
    input  logic                       mem_wb_en,
    input  logic [AW-1:0]              mem_dest,
    input  logic [DW-1:0]              mem_data,
    output logic                       wb_en,
    output logic [AW-1:0]              wb_dest,
    output logic [DW-1:0]              wb_value,
    output logic                       wb_stall,
    input  logic [AW-1:0]              fwd_src,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_value,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow,
    output logic                       bad_dest
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] PC_REG = AW'(15);

    logic [AW-1:0] q_dest [DEPTH];
    logic [DW-1:0] q_data [DEPTH];

    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] occ_reg;
    logic          wb_en_reg;
    logic [AW-1:0] wb_dest_reg;
    logic [DW-1:0] wb_value_reg;
    logic          overflow_reg, bad_dest_reg;

    logic          mem_ok, alu_ok, pop;
    logic          in0_v, in1_v;
    logic [AW-1:0] in0_dest;
    logic [DW-1:0] in0_data;
    logic          out_v;
    logic [AW-1:0] out_dest;
    logic [DW-1:0] out_data;
    logic          pa_v, pb_v, acc_a, acc_b, drop;
    logic [AW-1:0] pa_dest;
    logic [DW-1:0] pa_data;
    logic [CW-1:0] free_slots;
    logic [PW-1:0] tail_b;
    logic [CW-1:0] occ_next;
    logic [PW-1:0] head_next, tail_next;

    // Incoming requests compacted into an age-ordered pair: load first, then ALU.
    always_comb begin
        mem_ok   = mem_wb_en && (mem_dest != PC_REG);
        alu_ok   = alu_wb_en && (alu_dest != PC_REG);
        in0_v    = mem_ok || alu_ok;
        in0_dest = mem_ok ? mem_dest : alu_dest;
        in0_data = mem_ok ? mem_data : alu_result;
        in1_v    = mem_ok && alu_ok;
        pop      = (occ_reg != '0);
    end

    // The queue head always wins the output; otherwise the oldest incoming bypasses it.
    always_comb begin
        out_v      = pop || in0_v;
        out_dest   = pop ? q_dest[head_reg] : in0_dest;
        out_data   = pop ? q_data[head_reg] : in0_data;
        pa_v       = pop ? in0_v : in1_v;
        pa_dest    = pop ? in0_dest : alu_dest;
        pa_data    = pop ? in0_data : alu_result;
        pb_v       = pop && in1_v;
        free_slots = CW'(DEPTH) - occ_reg + CW'(pop);
        acc_a      = pa_v && (free_slots != '0);
        acc_b      = pb_v && (free_slots >= CW'(2));
        drop       = (pa_v && !acc_a) || (pb_v && !acc_b);
        tail_b     = tail_reg + PW'(1);
        occ_next   = occ_reg + CW'(acc_a) + CW'(acc_b) - CW'(pop);
        head_next  = head_reg + PW'(pop);
        tail_next  = tail_reg + PW'(acc_a) + PW'(acc_b);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] dest_reg;
            logic [DW-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (acc_a && (tail_reg == PW'(gi))) begin
                    dest_reg <= pa_dest;
                    data_reg <= pa_data;
                end else if (acc_b && (tail_b == PW'(gi))) begin
                    dest_reg <= alu_dest;
                    data_reg <= alu_result;
                end
            end

            assign q_dest[gi] = dest_reg;
            assign q_data[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            occ_reg      <= '0;
            wb_en_reg    <= 1'b0;
            wb_dest_reg  <= '0;
            wb_value_reg <= '0;
            overflow_reg <= 1'b0;
            bad_dest_reg <= 1'b0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            occ_reg   <= occ_next;
            wb_en_reg <= out_v;
            if (out_v) begin
                wb_dest_reg  <= out_dest;
                wb_value_reg <= out_data;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if ((mem_wb_en && (mem_dest == PC_REG)) || (alu_wb_en && (alu_dest == PC_REG))) begin
                bad_dest_reg <= 1'b1;
            end
        end
    end

    assign wb_en     = wb_en_reg;
    assign wb_dest   = wb_dest_reg;
    assign wb_value  = wb_value_reg;
    assign occupancy = occ_reg;
    assign overflow  = overflow_reg;
    assign bad_dest  = bad_dest_reg;
    assign wb_stall  = (CW'(DEPTH) - occ_reg) < CW'(2);

`ifdef WB_FWD_EN
    // Scan oldest to newest so the newest matching write overrides earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit   = 1'b0;
        fwd_value = '0;
        idx       = head_reg;
        if (fwd_src != PC_REG) begin
            if (wb_en_reg && (wb_dest_reg == fwd_src)) begin
                fwd_hit   = 1'b1;
                fwd_value = wb_value_reg;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_reg + PW'(k);
                if ((CW'(k) < occ_reg) && (q_dest[idx] == fwd_src)) begin
                    fwd_hit   = 1'b1;
                    fwd_value = q_data[idx];
                end
            end
        end
    end
`else
    logic unused_fwd_src;
    assign unused_fwd_src = ^fwd_src;
    assign fwd_hit        = 1'b0;
    assign fwd_value      = '0;
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer: directed scenarios with literal expectations, then random traffic
// checked every cycle against a list-based model of the write queue.
module tb_wb_write_sequencer;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_wb_en, mem_wb_en;
    logic [AW-1:0] alu_dest, mem_dest, fwd_src;
    logic [DW-1:0] alu_result, mem_data;
    logic          wb_en, wb_stall, fwd_hit, overflow, bad_dest;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_value, fwd_value;
    logic [CW-1:0] occupancy;

    always #5 clk = ~clk;

    wb_write_sequencer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_en(alu_wb_en), .alu_dest(alu_dest), .alu_result(alu_result),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_data(mem_data),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .wb_stall(wb_stall),
        .fwd_src(fwd_src), .fwd_hit(fwd_hit), .fwd_value(fwd_value),
        .occupancy(occupancy), .overflow(overflow), .bad_dest(bad_dest)
    );

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic          m_en = 1'b0;
    logic [AW-1:0] m_dest = '0;
    logic [DW-1:0] m_val = '0;
    logic          m_ovf = 1'b0, m_bad = 1'b0;
    bit            m_live = 1'b0;
    int            checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: everything pending plus this edge's requests forms one age-ordered list;
    // the head is written, and anything beyond DEPTH at the tail is lost.
    task automatic model_update();
        ent_t lst[$];
        ent_t e;
        if (rst) begin
            mq.delete();
            m_en = 1'b0; m_dest = '0; m_val = '0; m_ovf = 1'b0; m_bad = 1'b0;
            m_live = 1'b1;
        end else begin
            lst = mq;
            if (mem_wb_en) begin
                if (mem_dest == 4'd15) m_bad = 1'b1;
                else lst.push_back('{mem_dest, mem_data});
            end
            if (alu_wb_en) begin
                if (alu_dest == 4'd15) m_bad = 1'b1;
                else lst.push_back('{alu_dest, alu_result});
            end
            if (lst.size() > 0) begin
                e = lst.pop_front();
                m_en = 1'b1; m_dest = e.dest; m_val = e.data;
            end else begin
                m_en = 1'b0;
            end
            while (lst.size() > DEPTH) begin
                void'(lst.pop_back());
                m_ovf = 1'b1;
            end
            mq = lst;
        end
    endtask

    always @(negedge clk) begin
        logic          exp_hit;
        logic [DW-1:0] exp_fv;
        if (m_live) begin
            exp_hit = 1'b0;
            exp_fv  = '0;
`ifdef WB_FWD_EN
            if (fwd_src != 4'd15) begin
                if (m_en && m_dest == fwd_src) begin exp_hit = 1'b1; exp_fv = m_val; end
                foreach (mq[i]) if (mq[i].dest == fwd_src) begin exp_hit = 1'b1; exp_fv = mq[i].data; end
            end
`endif
            chk("wb_en", wb_en, m_en);
            chk("wb_dest", wb_dest, m_dest);
            chk("wb_value", wb_value, m_val);
            chk("occupancy", occupancy, mq.size());
            chk("wb_stall", wb_stall, (DEPTH - mq.size()) < 2);
            chk("overflow", overflow, m_ovf);
            chk("bad_dest", bad_dest, m_bad);
            chk("fwd_hit", fwd_hit, exp_hit);
            chk("fwd_value", fwd_value, exp_fv);
            if (wb_en) $display("cycle %0d: write r%0d <= %08h", cyc, wb_dest, wb_value);
        end
    end

    task automatic set_in(input logic me, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                          input logic ae, input logic [AW-1:0] ad, input logic [DW-1:0] adat);
        mem_wb_en = me; mem_dest = md; mem_data = mdat;
        alu_wb_en = ae; alu_dest = ad; alu_result = adat;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fwd_src = '0;
        idle_in();
        step();
        step();
        rst = 1'b0;

        repeat (5) begin
            step();
            chk("lit_idle_wb_en", wb_en, 1'b0);
            chk("lit_idle_occ", occupancy, 0);
            chk("lit_idle_stall", wb_stall, 1'b0);
            chk("lit_idle_ovf", overflow, 1'b0);
        end

        set_in(1'b0, '0, '0, 1'b1, 4'd3, 32'h0000_00AA);
        step();
        idle_in();
        chk("lit_single_en", wb_en, 1'b1);
        chk("lit_single_dest", wb_dest, 3);
        chk("lit_single_val", wb_value, 32'hAA);
        step();
        chk("lit_single_after", wb_en, 1'b0);

        set_in(1'b1, 4'd5, 32'h11, 1'b1, 4'd6, 32'h22);
        step();
        idle_in();
        chk("lit_pair_dest0", wb_dest, 5);
        chk("lit_pair_val0", wb_value, 32'h11);
        chk("lit_pair_occ0", occupancy, 1);
        step();
        chk("lit_pair_dest1", wb_dest, 6);
        chk("lit_pair_val1", wb_value, 32'h22);
        chk("lit_pair_occ1", occupancy, 0);

        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, AW'(2 * k + 1), 32'h100 + 32'(2 * k),
                   1'b1, AW'(2 * k + 2), 32'h101 + 32'(2 * k));
            step();
            if (k == 2) begin
                chk("lit_fill_occ3", occupancy, 3);
                chk("lit_fill_stall", wb_stall, 1'b1);
            end
            if (k == 3) begin
                chk("lit_fill_occ4", occupancy, 4);
                chk("lit_fill_no_ovf", overflow, 1'b0);
            end
            if (k == 4) begin
                chk("lit_full_occ", occupancy, 4);
                chk("lit_full_ovf", overflow, 1'b1);
            end
        end
        idle_in();
        repeat (4) step();
        chk("lit_drain_dest", wb_dest, 9);
        chk("lit_drain_val", wb_value, 32'h108);
        step();
        chk("lit_drain_done", wb_en, 1'b0);

        set_in(1'b0, '0, '0, 1'b1, 4'd15, 32'hDEAD);
        step();
        idle_in();
        chk("lit_pc_no_write", wb_en, 1'b0);
        chk("lit_pc_bad", bad_dest, 1'b1);
        step();
        chk("lit_pc_sticky", bad_dest, 1'b1);

        fwd_src = 4'd2;
        set_in(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h10);
        step();
        set_in(1'b1, 4'd3, 32'h3, 1'b1, 4'd2, 32'h20);
        step();
        idle_in();
`ifdef WB_FWD_EN
        chk("lit_fwd_hit", fwd_hit, 1'b1);
        chk("lit_fwd_val", fwd_value, 32'h20);
`else
        chk("lit_fwd_off", fwd_hit, 1'b0);
`endif
        fwd_src = 4'd7;
        #1;
        chk("lit_fwd_miss", fwd_hit, 1'b0);
        repeat (3) step();

        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, AW'(k + 1), 32'h200 + 32'(k), 1'b1, AW'(k + 4), 32'h300 + 32'(k));
            step();
        end
        chk("lit_prerst_occ", occupancy, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_in();
        chk("lit_rst_occ", occupancy, 0);
        chk("lit_rst_wb_en", wb_en, 1'b0);
        chk("lit_rst_bad", bad_dest, 1'b0);
        repeat (3) begin
            step();
            chk("lit_rst_quiet", wb_en, 1'b0);
        end

        repeat (1500) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in(($urandom_range(0, 9) < 6), AW'($urandom_range(0, 15)), $urandom,
                   ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 15)), $urandom);
            fwd_src = AW'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;
        idle_in();
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
